// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: fetches a MIPS word, decodes it into ALU
// operands, waits one cycle for an external ALU, then writes back the result.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_f,
    input  logic [31:0] alu_y,
    input  logic [3:0]  alu_zero,
    output logic        done,
    output logic        illegal,
    output logic        zero_flag,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [31:0] instr_r;
    logic [31:0] regs_r [32];
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [3:0]  alu_f_r;
    logic [31:0] result_r;
    logic [4:0]  dest_r;
    logic        illegal_pend_r;
    logic        done_r;
    logic        illegal_r;
    logic        zero_flag_r;

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic        dec_legal_s;
    logic [3:0]  dec_f_s;
    logic [31:0] dec_b_s;
    logic [4:0]  dec_dest_s;
    logic        unused_s;

    assign opcode_s = instr_r[31:26];
    assign rs_s     = instr_r[25:21];
    assign rt_s     = instr_r[20:16];
    assign rd_s     = instr_r[15:11];
    assign funct_s  = instr_r[5:0];

    // Register 0 is forced to read zero regardless of array contents.
    assign rs_val_s = (rs_s == 5'd0) ? 32'd0 : regs_r[rs_s];
    assign rt_val_s = (rt_s == 5'd0) ? 32'd0 : regs_r[rt_s];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_r[dbg_addr];

    assign instr_ready = (state_r == IDLE);
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_f       = alu_f_r;
    assign done        = done_r;
    assign illegal     = illegal_r;
    assign zero_flag   = zero_flag_r;
    assign unused_s    = ^alu_zero[3:1];

    // Instruction decode: legality, ALU function, operand B source and destination.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_f_s     = 4'd0;
        dec_b_s     = rt_val_s;
        dec_dest_s  = rd_s;
        case (opcode_s)
            6'h00: begin
                case (funct_s)
                    6'h20: begin dec_legal_s = 1'b1; dec_f_s = 4'd2; end
                    6'h22: begin dec_legal_s = 1'b1; dec_f_s = 4'd6; end
                    6'h24: begin dec_legal_s = 1'b1; dec_f_s = 4'd1; end
                    6'h25: begin dec_legal_s = 1'b1; dec_f_s = 4'd3; end
                    6'h2A: begin dec_legal_s = 1'b1; dec_f_s = 4'd7; end
                    default: begin dec_legal_s = 1'b0; dec_f_s = 4'd0; end
                endcase
            end
            6'h08: begin
                dec_legal_s = 1'b1;
                dec_f_s     = 4'd2;
                dec_b_s     = {{16{instr_r[15]}}, instr_r[15:0]};
                dec_dest_s  = rt_s;
            end
            default: begin
                dec_legal_s = 1'b0;
                dec_f_s     = 4'd0;
            end
        endcase
    end

    // Next-state logic; unsupported instructions skip EXEC.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    state_next_s = DECODE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DECODE: begin
                if (dec_legal_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = WB;
                end
            end
            EXEC:    state_next_s = WB;
            WB:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control state, operand registers, result capture and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            instr_r        <= 32'd0;
            alu_a_r        <= 32'd0;
            alu_b_r        <= 32'd0;
            alu_f_r        <= 4'd0;
            result_r       <= 32'd0;
            dest_r         <= 5'd0;
            illegal_pend_r <= 1'b0;
            done_r         <= 1'b0;
            illegal_r      <= 1'b0;
            zero_flag_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        instr_r <= instr;
                    end
                end
                DECODE: begin
                    if (dec_legal_s) begin
                        alu_a_r        <= rs_val_s;
                        alu_b_r        <= dec_b_s;
                        alu_f_r        <= dec_f_s;
                        dest_r         <= dec_dest_s;
                        illegal_pend_r <= 1'b0;
                    end else begin
                        illegal_pend_r <= 1'b1;
                        done_r         <= 1'b1;
                        illegal_r      <= 1'b1;
                    end
                end
                EXEC: begin
                    result_r    <= alu_y;
                    zero_flag_r <= alu_zero[0];
                    done_r      <= 1'b1;
                end
                WB: begin
                    illegal_pend_r <= illegal_pend_r;
                end
                default: begin
                    illegal_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written once when WB retires a legal op.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if ((state_r == WB) && !illegal_pend_r && (dest_r != 5'd0)) begin
            regs_r[dest_r] <= result_r;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU on alu_a/alu_b/alu_f.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_f;
    logic [31:0] alu_y;
    logic [3:0]  alu_zero;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .alu_zero(alu_zero), .done(done), .illegal(illegal), .zero_flag(zero_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU; upper zero bits carry junk that the controller must ignore.
    always_comb begin
        case (alu_f)
            4'd2:    alu_y = alu_a + alu_b;
            4'd6:    alu_y = alu_a - alu_b;
            4'd1:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            4'd7:    alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = 32'd0;
        endcase
    end
    assign alu_zero = {3'b101, (alu_y == 32'd0)};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Starts at a negedge in IDLE; returns at the negedge after the acceptance edge.
    task automatic send(input logic [31:0] w);
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'hDEADBEEF;
        @(negedge clk);
        chk("done_decode", {31'd0, done}, 32'd0);
        chk("ready_decode", {31'd0, instr_ready}, 32'd0);
    endtask

    task automatic run_legal(input string tag, input logic [31:0] w, input logic [3:0] f,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                             input logic [31:0] val, input logic z);
        send(w);
        @(posedge clk); @(negedge clk);
        chk({tag, "_f"}, {28'd0, alu_f}, {28'd0, f});
        chk({tag, "_a"}, alu_a, a);
        chk({tag, "_b"}, alu_b, b);
        chk({tag, "_done_exec"}, {31'd0, done}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, z});
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        rd_reg({tag, "_reg"}, dst, val);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w, input logic zkeep,
                               input logic [4:0] dst);
        send(w);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd1);
        chk({tag, "_zero_held"}, {31'd0, zero_flag}, {31'd0, zkeep});
        chk({tag, "_f_held"}, {28'd0, alu_f}, 32'd6);
        chk({tag, "_a_held"}, alu_a, 32'd5);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_illegal_after"}, {31'd0, illegal}, 32'd0);
        chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        rd_reg({tag, "_dest"}, dst, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_f", {28'd0, alu_f}, 32'd0);
        chk("rst_zero", {31'd0, zero_flag}, 32'd0);
        rd_reg("rst_r1", 5'd1, 32'd0);

        run_legal("addi_r1", addi(5'd1, 5'd0, 16'd5), 4'd2, 32'd0, 32'd5, 5'd1, 32'd5, 1'b0);
        run_legal("addi_r2", addi(5'd2, 5'd0, 16'hFFFD), 4'd2, 32'd0, 32'hFFFFFFFD, 5'd2,
                  32'hFFFFFFFD, 1'b0);
        run_legal("add_r3", rtype(5'd1, 5'd2, 5'd3, 6'h20), 4'd2, 32'd5, 32'hFFFFFFFD, 5'd3,
                  32'd2, 1'b0);
        run_legal("slt_r4", rtype(5'd2, 5'd1, 5'd4, 6'h2A), 4'd7, 32'hFFFFFFFD, 32'd5, 5'd4,
                  32'd1, 1'b0);
        run_legal("and_r7", rtype(5'd1, 5'd2, 5'd7, 6'h24), 4'd1, 32'd5, 32'hFFFFFFFD, 5'd7,
                  32'd5, 1'b0);
        run_legal("or_r8", rtype(5'd1, 5'd2, 5'd8, 6'h25), 4'd3, 32'd5, 32'hFFFFFFFD, 5'd8,
                  32'hFFFFFFFD, 1'b0);
        run_legal("sub_r5", rtype(5'd1, 5'd1, 5'd5, 6'h22), 4'd6, 32'd5, 32'd5, 5'd5,
                  32'd0, 1'b1);

        run_illegal("nor_r9", rtype(5'd1, 5'd2, 5'd9, 6'h27), 1'b1, 5'd9);
        run_illegal("lw_r11", 32'h8C2B0004, 1'b1, 5'd11);
        rd_reg("post_illegal_r1", 5'd1, 32'd5);
        rd_reg("post_illegal_r5", 5'd5, 32'd0);

        run_legal("add_r0", rtype(5'd1, 5'd1, 5'd0, 6'h20), 4'd2, 32'd5, 32'd5, 5'd0,
                  32'd0, 1'b0);

        // Back-to-back: valid held high, acceptances land every fourth cycle.
        instr_valid = 1'b1;
        instr       = rtype(5'd1, 5'd1, 5'd10, 6'h20);
        for (int i = 0; i < 12; i++) begin
            chk("stream_ready", {31'd0, instr_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk("stream_done", {31'd0, done}, (i % 4 == 3) ? 32'd1 : 32'd0);
            @(posedge clk); @(negedge clk);
        end
        instr_valid = 1'b0;
        rd_reg("stream_r10", 5'd10, 32'd10);

        // Reset during EXEC must abort the write-back.
        send(rtype(5'd1, 5'd1, 5'd6, 6'h20));
        @(posedge clk); @(negedge clk);
        chk("abort_in_exec_f", {28'd0, alu_f}, 32'd2);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_illegal", {31'd0, illegal}, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_b", alu_b, 32'd0);
        chk("abort_alu_f", {28'd0, alu_f}, 32'd0);
        chk("abort_zero", {31'd0, zero_flag}, 32'd0);
        rd_reg("abort_r6", 5'd6, 32'd0);
        rd_reg("abort_r1", 5'd1, 32'd0);
        rd_reg("abort_r10", 5'd10, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_reg("abort_r6_late", 5'd6, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
